// File: rtl/alu_seq_ctrl_if.sv
// Request/response channel between decode/issue and alu_seq_ctrl.
// req_op carries the 4-bit cs_alu_op encoding defined in alu_seq_ctrl.
interface alu_seq_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic            req_flip;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;

  modport master (
    output req_valid, req_op, req_flip, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_op, req_flip, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Runs XLEN-bit ALU ops as two half-word passes on the shared HALF_W serial ALU.
// Optional macro ALU_SEQ_EARLY_OUT_EN: EQ finishes after P1 when the low halves differ.
module alu_seq_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned HALF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_seq_ctrl_if.slave     bus,
  output logic              alu_first_cycle_o,
  output logic [3:0]        alu_op_o,
  output logic              alu_cmp_flip_o,
  output logic [HALF_W-1:0] alu_a_o,
  output logic [HALF_W-1:0] alu_b_o,
  input  logic [HALF_W-1:0] alu_result_i,
  input  logic              alu_cmp_result_i,
  input  logic              alu_cmp_result_valid_i,
  output logic              busy_o
);

  typedef enum logic [3:0] {
    AluOpAnd   = 4'd0,
    AluOpAdd   = 4'd1,
    AluOpSub   = 4'd2,
    AluOpOr    = 4'd3,
    AluOpXor   = 4'd4,
    AluOpEq    = 4'd5,
    AluOpLt    = 4'd6,
    AluOpLtu   = 4'd7,
    AluOpSll   = 4'd8,
    AluOpSrl   = 4'd9,
    AluOpSra   = 4'd10,
    AluOpPlus4 = 4'd11
  } cs_alu_op;

  typedef enum logic [1:0] {StIdle, StP1, StP2, StResp} state_e;

  localparam int unsigned ShW = $clog2(XLEN);
  // Shift-amount bit that selects the single-pass (wide) path.
  localparam logic [HALF_W-1:0] WideMask = HALF_W'(1) << (ShW - 1);

  state_e          state_q, state_d;
  cs_alu_op        op_q, op_d;
  logic            flip_q, flip_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;

  logic              is_shift, hi_first, is_cmp, wide;
  logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi, shamt_b, sra_fill;

  assign is_shift = op_q inside {AluOpSll, AluOpSrl, AluOpSra};
  assign hi_first = op_q inside {AluOpSrl, AluOpSra};
  assign is_cmp   = op_q inside {AluOpEq, AluOpLt, AluOpLtu};
  assign wide     = is_shift && b_q[ShW-1];
  assign a_lo     = a_q[HALF_W-1:0];
  assign a_hi     = a_q[XLEN-1:HALF_W];
  assign b_lo     = b_q[HALF_W-1:0];
  assign b_hi     = b_q[XLEN-1:HALF_W];
  assign shamt_b  = b_lo & ~WideMask;
  assign sra_fill = (op_q == AluOpSra) ? {HALF_W{a_q[XLEN-1]}} : '0;

`ifndef ALU_SEQ_EARLY_OUT_EN
  logic unused_cmp_valid;
  assign unused_cmp_valid = alu_cmp_result_valid_i;
`endif

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    flip_d            = flip_q;
    a_d               = a_q;
    b_d               = b_q;
    res_d             = res_q;
    bus.req_ready     = 1'b0;
    bus.rsp_valid     = 1'b0;
    alu_first_cycle_o = 1'b1;
    alu_op_o          = op_q;
    alu_cmp_flip_o    = flip_q;
    alu_a_o           = '0;
    alu_b_o           = '0;

    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d    = cs_alu_op'(bus.req_op);
          flip_d  = bus.req_flip;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          if (cs_alu_op'(bus.req_op) == AluOpPlus4) begin
            op_d = AluOpAdd;
            b_d  = XLEN'(4);
          end
          state_d = StP1;
        end
      end
      StP1: begin
        alu_a_o = hi_first ? a_hi : a_lo;
        alu_b_o = is_shift ? shamt_b : b_lo;
        state_d = StP2;
        if (wide) begin
          if (hi_first) res_d = {sra_fill, alu_result_i};
          else          res_d = {alu_result_i, {HALF_W{1'b0}}};
          state_d = StResp;
        end else if (!is_cmp) begin
          if (hi_first) res_d[XLEN-1:HALF_W] = alu_result_i;
          else          res_d[HALF_W-1:0]    = alu_result_i;
        end
`ifdef ALU_SEQ_EARLY_OUT_EN
        else if (op_q == AluOpEq && alu_cmp_result_valid_i) begin
          // Low halves already differ, so the high pass cannot change the answer.
          res_d   = XLEN'(alu_cmp_result_i);
          state_d = StResp;
        end
`endif
      end
      StP2: begin
        alu_first_cycle_o = 1'b0;
        alu_a_o = hi_first ? a_lo : a_hi;
        alu_b_o = is_shift ? shamt_b : b_hi;
        if (is_cmp)        res_d = XLEN'(alu_cmp_result_i);
        else if (hi_first) res_d[HALF_W-1:0]    = alu_result_i;
        else               res_d[XLEN-1:HALF_W] = alu_result_i;
        state_d = StResp;
      end
      StResp: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.rsp_result = res_q;
  assign busy_o         = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= AluOpAnd;
      flip_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      flip_q  <= flip_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural 16-bit serial ALU model.
module tb_alu_seq_ctrl;

  localparam logic [3:0] OpAnd = 4'd0, OpAdd = 4'd1, OpSub = 4'd2, OpOr = 4'd3, OpXor = 4'd4;
  localparam logic [3:0] OpEq = 4'd5, OpLt = 4'd6, OpLtu = 4'd7, OpSll = 4'd8, OpSrl = 4'd9;
  localparam logic [3:0] OpSra = 4'd10, OpPlus4 = 4'd11;

`ifdef ALU_SEQ_EARLY_OUT_EN
  localparam int EqMissLat = 2;
`else
  localparam int EqMissLat = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.XLEN(32)) bus ();

  logic        alu_first, alu_flip, alu_cmp, alu_cmp_vld, busy;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_res;

  alu_seq_ctrl #(.XLEN(32), .HALF_W(16)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .bus                    (bus),
    .alu_first_cycle_o      (alu_first),
    .alu_op_o               (alu_op),
    .alu_cmp_flip_o         (alu_flip),
    .alu_a_o                (alu_a),
    .alu_b_o                (alu_b),
    .alu_result_i           (alu_res),
    .alu_cmp_result_i       (alu_cmp),
    .alu_cmp_result_valid_i (alu_cmp_vld),
    .busy_o                 (busy)
  );

  // Serial ALU model: c_q carries carry/borrow/ne, sh_q carries shifted-out bits.
  logic               c_q, c_d, c_in, ne, lt;
  logic [15:0]        sh_q, sh_d;
  logic [16:0]        t17;
  logic [31:0]        t32;
  logic signed [17:0] s18;

  always_comb begin
    c_in = alu_first ? 1'b0 : c_q;
    alu_res = '0; alu_cmp = 1'b0; alu_cmp_vld = 1'b0;
    c_d = c_q; sh_d = sh_q; t17 = '0; t32 = '0; s18 = '0; ne = 1'b0; lt = 1'b0;
    case (alu_op)
      OpAdd: begin
        t17 = {1'b0, alu_a} + {1'b0, alu_b} + 17'(c_in);
        alu_res = t17[15:0]; c_d = t17[16];
      end
      OpSub, OpLt, OpLtu: begin
        t17 = {1'b0, alu_a} - {1'b0, alu_b} - 17'(c_in);
        alu_res = t17[15:0]; c_d = t17[16];
        s18 = $signed({{2{alu_a[15]}}, alu_a}) - $signed({{2{alu_b[15]}}, alu_b}) - 18'(c_in);
        lt = (alu_op == OpLt) ? s18[17] : t17[16];
        alu_cmp = lt ^ alu_flip;
        alu_cmp_vld = !alu_first;
      end
      OpAnd: alu_res = alu_a & alu_b;
      OpOr:  alu_res = alu_a | alu_b;
      OpXor: alu_res = alu_a ^ alu_b;
      OpEq: begin
        ne = (alu_a != alu_b) || c_in;
        c_d = ne;
        alu_cmp = !ne ^ alu_flip;
        alu_cmp_vld = alu_first ? (alu_a != alu_b) : 1'b1;
      end
      OpSll: begin
        t32 = {16'b0, alu_a} << alu_b[3:0];
        alu_res = t32[15:0] | (alu_first ? 16'h0 : sh_q); sh_d = t32[31:16];
      end
      OpSrl, OpSra: begin
        if (alu_op == OpSra && alu_first) t32 = $signed({alu_a, 16'b0}) >>> alu_b[3:0];
        else                              t32 = {alu_a, 16'b0} >> alu_b[3:0];
        alu_res = t32[31:16] | (alu_first ? 16'h0 : sh_q); sh_d = t32[15:0];
      end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    c_q  <= c_d;
    sh_q <= sh_d;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_rsp = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
    end
  endtask

  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];
  int          acc_q[$];
  string       name_q[$];

  // Monitor: pops the scoreboard on each response handshake.
  logic        seen = 1'b0;
  int          first_cyc = 0;
  logic [31:0] held = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bus.rsp_valid) begin
      if (!seen) begin
        seen = 1'b1; first_cyc = cyc; held = bus.rsp_result;
      end else begin
        check("rsp_stable", bus.rsp_result, held);
      end
      check("req_ready_in_resp", {31'b0, bus.req_ready}, 32'd0);
      if (bus.rsp_ready) begin
        n_rsp++;
        seen = 1'b0;
        if (exp_res_q.size() == 0) begin
          check("unexpected_rsp", bus.rsp_result, 32'hxxxx_xxxx);
        end else begin
          automatic string nm = name_q.pop_front();
          check({nm, "_result"}, bus.rsp_result, exp_res_q.pop_front());
          check({nm, "_latency"}, 32'(first_cyc - acc_q.pop_front()), 32'(exp_lat_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] p1_a, p1_b, p2_a;
  logic        p1_first, p2_first;

  task automatic issue(input string nm, input logic [3:0] op, input logic flip,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                       input int lat, input int stall);
    int guard;
    bus.rsp_ready = (stall == 0);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_flip = flip; bus.req_a = a; bus.req_b = b;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin tick(); guard++; end
    check({nm, "_accept"}, {31'b0, bus.req_ready}, 32'd1);
    if (!bus.req_ready) begin bus.req_valid = 1'b0; return; end
    exp_res_q.push_back(exp); exp_lat_q.push_back(lat); acc_q.push_back(cyc);
    name_q.push_back(nm);
    tick();
    bus.req_valid = 1'b0;
    p1_a = alu_a; p1_b = alu_b; p1_first = alu_first;
    check({nm, "_busy"}, {31'b0, busy}, 32'd1);
    tick();
    p2_a = alu_a; p2_first = alu_first;
    if (stall > 0) begin
      guard = 0;
      while (!bus.rsp_valid && guard < 20) begin tick(); guard++; end
      repeat (stall) tick();
      bus.rsp_ready = 1'b1;
    end
    guard = 0;
    while (exp_res_q.size() != 0 && guard < 50) begin tick(); guard++; end
    check({nm, "_drained"}, 32'(exp_res_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rsp_before;
    bus.req_valid = 1'b0; bus.req_op = OpAnd; bus.req_flip = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_first", {31'b0, alu_first}, 32'd1);
    check("rst_alu_op", {28'b0, alu_op}, {28'b0, OpAnd});
    check("rst_alu_a", {16'b0, alu_a}, 32'd0);
    check("rst_alu_b", {16'b0, alu_b}, 32'd0);
    check("rst_flip", {31'b0, alu_flip}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    issue("add", OpAdd, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 3, 0);
    check("add_p1_a", {16'b0, p1_a}, 32'hFFFF);
    check("add_p2_a", {16'b0, p2_a}, 32'h0000);
    check("add_p1_first", {31'b0, p1_first}, 32'd1);
    check("add_p2_first", {31'b0, p2_first}, 32'd0);

    issue("sra_wide", OpSra, 1'b0, 32'h8000_1234, 32'd20, 32'hFFFF_F800, 2, 0);
    check("sra_wide_p1_a", {16'b0, p1_a}, 32'h8000);
    check("sra_wide_p1_b", {16'b0, p1_b}, 32'h0004);

    issue("sll", OpSll, 1'b0, 32'h0000_8001, 32'd4, 32'h0008_0010, 3, 0);
    check("sll_p1_a", {16'b0, p1_a}, 32'h8001);

    issue("eq_miss", OpEq, 1'b0, 32'h1234_0001, 32'h1234_0002, 32'd0, EqMissLat, 0);
    issue("lt_ge_stall", OpLt, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 3, 5);

    issue("sub", OpSub, 1'b0, 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 3, 0);
    issue("xor", OpXor, 1'b0, 32'hF0F0_1234, 32'h0F0F_1234, 32'hFFFF_0000, 3, 0);
    issue("and", OpAnd, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 3, 0);
    issue("or", OpOr, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 3, 0);
    issue("plus4", OpPlus4, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678, 32'h0000_0002, 3, 0);
    check("plus4_p1_b", {16'b0, p1_b}, 32'h0004);
    issue("eq_hit", OpEq, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1, 3, 0);
    issue("ne_hit", OpEq, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 3, 0);
    issue("ltu", OpLtu, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'd1, 3, 0);
    issue("srl", OpSrl, 1'b0, 32'h1234_5678, 32'd8, 32'h0012_3456, 3, 0);
    check("srl_p1_a", {16'b0, p1_a}, 32'h1234);
    issue("sra", OpSra, 1'b0, 32'h8000_1234, 32'd4, 32'hF800_0123, 3, 0);
    issue("srl_wide", OpSrl, 1'b0, 32'h8000_0000, 32'd31, 32'h0000_0001, 2, 0);
    issue("sll_wide", OpSll, 1'b0, 32'h0000_ABCD, 32'd16, 32'hABCD_0000, 2, 0);

    // Reset during P2 of a SUB: the op must vanish without a response.
    rsp_before = n_rsp;
    bus.req_valid = 1'b1; bus.req_op = OpSub; bus.req_flip = 1'b0;
    bus.req_a = 32'h0000_0005; bus.req_b = 32'h0000_0003;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("rst_mid_p2_first", {31'b0, alu_first}, 32'd0);
    rst_n = 1'b0;
    tick();
    check("rst_mid_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_mid_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (6) tick();
    check("rst_mid_no_rsp", 32'(n_rsp - rsp_before), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
